// File: rtl/serial_adder_pkg.sv
// Shared types for the bit-serial adder: FSM state encoding and counter sizing.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package serial_adder_pkg;

  // Two-bit state encoding; the fourth code is unused and recovers to idle.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Bit counter only has to reach WIDTH-1, so $clog2(WIDTH) bits suffice.
  function automatic int cnt_width(input int width);
    return (width > 1) ? $clog2(width) : 1;
  endfunction

endpackage

// File: rtl/serial_adder_full_adder_cell.sv
// One-bit combinational full adder: the single arithmetic cell of the serial adder.
// Latency: 0 cycles (purely combinational).
// Backpressure: none; outputs follow inputs.
//
// Ports:
//   a, b, cin  - operand bits and carry-in
//   sum, cout  - sum bit and carry-out
module full_adder_cell (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  logic half_sum;

  assign half_sum = a ^ b;
  assign sum      = half_sum ^ cin;
  assign cout     = (a & b) | (cin & half_sum);

endmodule

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: one full-adder cell, LSB first, registered carry between bits.
// Latency: WIDTH+1 clock edges from accepted start to the done pulse.
// Backpressure: start is only honoured in IDLE or DONE; a start during RUN is dropped.
//
// Ports:
//   clk, rst        - clock, asynchronous active-high reset
//   start           - request; a, b, cin captured when accepted
//   busy            - high while bits are being processed
//   done            - one-cycle pulse, sum/cout (and ovf) valid from here on
//   sum, cout       - {cout, sum} = a + b + cin, held until the next accepted start
//   ovf             - signed overflow, only when SERIAL_ADDER_OVF_EN is defined
// WIDTH legal range is 2..32.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef SERIAL_ADDER_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int               CNT_W    = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  state_t           state;
  state_t           state_nxt;
  logic             accept;
  logic             last_bit;

  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [CNT_W-1:0] bit_cnt;
  logic             carry;
  logic             cell_sum;
  logic             cell_cout;

  full_adder_cell u_cell (
    .a    (op_a[0]),
    .b    (op_b[0]),
    .cin  (carry),
    .sum  (cell_sum),
    .cout (cell_cout)
  );

  assign last_bit = (bit_cnt == LAST_BIT);
  assign busy     = (state == ST_RUN);
  assign done     = (state == ST_DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          accept    = 1'b1;
          state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        if (last_bit) begin
          state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        // Back-to-back start is taken here so there is no idle gap.
        if (start) begin
          accept    = 1'b1;
          state_nxt = ST_RUN;
        end else begin
          state_nxt = ST_IDLE;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_a    <= '0;
      op_b    <= '0;
      bit_cnt <= '0;
      carry   <= 1'b0;
      sum     <= '0;
      cout    <= 1'b0;
    end else if (accept) begin
      op_a    <= a;
      op_b    <= b;
      carry   <= cin;
      bit_cnt <= '0;
      sum     <= '0;
      cout    <= 1'b0;
    end else if (state == ST_RUN) begin
      // Result bits enter at the MSB; after WIDTH shifts bit 0 sits at sum[0].
      sum   <= {cell_sum, sum[WIDTH-1:1]};
      carry <= cell_cout;
      op_a  <= op_a >> 1;
      op_b  <= op_b >> 1;
      if (last_bit) begin
        cout <= cell_cout;
      end else begin
        // Counter parks at WIDTH-1 instead of wrapping.
        bit_cnt <= bit_cnt + CNT_W'(1);
      end
    end
  end

`ifdef SERIAL_ADDER_OVF_EN
  // During the last bit the carry flop holds the carry into the MSB;
  // signed overflow is that carry differing from the carry out.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf <= 1'b0;
    end else if (accept) begin
      ovf <= 1'b0;
    end else if ((state == ST_RUN) && last_bit) begin
      ovf <= carry ^ cell_cout;
    end
  end
`endif

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder (WIDTH=8): directed vectors plus a cycle-level reference.
// Latency: n/a (testbench).
// Backpressure: n/a (testbench).
module tb_serial_adder;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         cin = 1'b0;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;
`ifdef SERIAL_ADDER_OVF_EN
  logic         ovf;
`endif

  int checks   = 0;
  int failures = 0;

  serial_adder #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
`ifdef SERIAL_ADDER_OVF_EN
    ,
    .ovf   (ovf)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: an add accepted at edge s0 is busy after edges s0..s0+W-1,
  // pulses done after edge s0+W, and a new start is accepted from edge s0+W+1.
  bit           m_active = 1'b0;
  int           m_edge   = 0;
  int           m_s0     = 0;
  logic [W:0]   m_res    = '0;
  logic         m_ovf    = 1'b0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_active = 1'b0;
      m_res    = '0;
      m_ovf    = 1'b0;
    end else begin
      m_edge++;
      if (start && (!m_active || (m_edge - m_s0) >= W + 1)) begin
        m_active = 1'b1;
        m_s0     = m_edge;
        m_res    = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
        m_ovf    = (a[W-1] == b[W-1]) && (m_res[W-1] != a[W-1]);
      end
    end
  end

  always @(negedge clk) begin
    int  d;
    bit  exp_busy;
    bit  exp_done;
    bit  res_known;
    d         = m_edge - m_s0;
    exp_busy  = m_active && (d < W);
    exp_done  = m_active && (d == W);
    res_known = !m_active || (d >= W);
    chk("cyc_busy", {31'd0, busy}, {31'd0, exp_busy});
    chk("cyc_done", {31'd0, done}, {31'd0, exp_done});
    chk("cyc_busy_done_excl", {31'd0, busy & done}, 32'd0);
    if (res_known) begin
      chk("cyc_sum", {24'd0, sum}, {24'd0, m_res[W-1:0]});
      chk("cyc_cout", {31'd0, cout}, {31'd0, m_res[W]});
`ifdef SERIAL_ADDER_OVF_EN
      chk("cyc_ovf", {31'd0, ovf}, {31'd0, m_ovf});
`endif
    end
  end

  // Counts negedges after the start edge until done is seen (bounded).
  task automatic wait_done(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!done && n < 30);
  endtask

  task automatic issue(input logic [W-1:0] ta, input logic [W-1:0] tb_, input logic tc);
    @(negedge clk);
    start = 1'b1;
    a     = ta;
    b     = tb_;
    cin   = tc;
    @(posedge clk);
  endtask

  // Drop start and scramble operands to show the captured copy is used.
  task automatic release_inputs();
    #1;
    start = 1'b0;
    a     = W'($urandom);
    b     = W'($urandom);
    cin   = 1'($urandom);
  endtask

  task automatic run_add(input string nm, input logic [W-1:0] ta, input logic [W-1:0] tb_,
                         input logic tc, input logic [W-1:0] esum, input logic ecout,
                         input logic eovf);
    int n;
    issue(ta, tb_, tc);
    release_inputs();
    wait_done(n);
    chk({nm, "_latency"}, n, W + 1);
    chk({nm, "_sum"}, {24'd0, sum}, {24'd0, esum});
    chk({nm, "_cout"}, {31'd0, cout}, {31'd0, ecout});
`ifdef SERIAL_ADDER_OVF_EN
    chk({nm, "_ovf"}, {31'd0, ovf}, {31'd0, eovf});
`else
    if (eovf === 1'bx) $display("unexpected x");
`endif
  endtask

  initial begin
    int n;
    int dones;

    repeat (2) @(negedge clk);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_sum", {24'd0, sum}, 32'd0);
    chk("idle_cout", {31'd0, cout}, 32'd0);

    run_add("add_5a_3c", 8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0, 1'b1);
    run_add("add_ff_01", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
    run_add("add_ff_ff_c", 8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0);

    // Start pulsed in the third RUN cycle must be ignored.
    issue(8'h10, 8'h20, 1'b0);
    release_inputs();
    repeat (3) @(negedge clk);
    start = 1'b1;
    a     = 8'hAA;
    b     = 8'h55;
    @(posedge clk);
    #1 start = 1'b0;
    dones = 0;
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      if (done) begin
        dones++;
        chk("ign_sum", {24'd0, sum}, 32'h30);
        chk("ign_cout", {31'd0, cout}, 32'd0);
      end
    end
    chk("ign_done_count", dones, 1);

    // Asynchronous reset in the fourth RUN cycle.
    issue(8'h5A, 8'h3C, 1'b0);
    release_inputs();
    repeat (4) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst_busy", {31'd0, busy}, 32'd0);
    chk("arst_done", {31'd0, done}, 32'd0);
    chk("arst_sum", {24'd0, sum}, 32'd0);
    chk("arst_cout", {31'd0, cout}, 32'd0);
`ifdef SERIAL_ADDER_OVF_EN
    chk("arst_ovf", {31'd0, ovf}, 32'd0);
`endif
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    dones = 0;
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      if (done) dones++;
    end
    chk("arst_no_done", dones, 0);
    run_add("add_01_01", 8'h01, 8'h01, 1'b0, 8'h02, 1'b0, 1'b0);

    // Start held high: second add accepted in the DONE cycle.
    issue(8'h80, 8'h80, 1'b0);
    wait_done(n);
    chk("b2b1_latency", n, W + 1);
    chk("b2b1_sum", {24'd0, sum}, 32'h00);
    chk("b2b1_cout", {31'd0, cout}, 32'd1);
    a = 8'h7F;
    b = 8'h01;
    @(posedge clk);
    release_inputs();
    wait_done(n);
    chk("b2b2_latency", n, W + 1);
    chk("b2b2_sum", {24'd0, sum}, 32'h80);
    chk("b2b2_cout", {31'd0, cout}, 32'd0);
`ifdef SERIAL_ADDER_OVF_EN
    chk("b2b2_ovf", {31'd0, ovf}, 32'd1);
`endif
    repeat (3) @(negedge clk);
    chk("final_hold_sum", {24'd0, sum}, 32'h80);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
